controller_rx: RTL and testbench
================================

CONTROLLER_RX -- requirements
Module: controller_rx

Interface
REQ-001 Parameter DATA_WIDTH, default 8, number of data bits per frame.
REQ-002 clk  input  1  oversampling clock at Prescale x baud rate.
REQ-003 rst  input  1  reset: asynchronous, active-low.
REQ-004 RX_IN  input  1  serial line, idle-high, already synchronous to clk (synchronizer upstream).
REQ-005 Prescale  input  6  oversampling ratio; legal values 8, 16, 32; other values give undefined behaviour.
REQ-006 PAR_EN  input  1  1 = parity bit present after the data bits.
REQ-007 PAR_TYP  input  1  0 = even parity, 1 = odd parity.
REQ-008 P_DATA  output  DATA_WIDTH  last received data word, LSB first on the line.
REQ-009 Data_Valid  output  1  one-cycle pulse, frame received without error.
REQ-010 Par_Err  output  1  one-cycle pulse, parity mismatch in the frame.
REQ-011 Stp_Err  output  1  one-cycle pulse, stop bit sampled as 0.

Function
REQ-012 Frame format SHALL be start(0), DATA_WIDTH data bits LSB first, optional parity, stop(1); each bit lasts Prescale clk cycles.
REQ-013 States SHALL be IDLE, START, DATA, PARITY, STOP; unused encodings SHALL go to IDLE.
REQ-014 An edge counter SHALL count 0..Prescale-1 within each bit, wrapping to 0 after Prescale-1; a bit counter SHALL count data bits 0..DATA_WIDTH-1.
REQ-015 IDLE: when RX_IN=0, that cycle SHALL count as edge 0 of the start bit; next state START with edge counter = 1. PAR_EN, PAR_TYP and Prescale SHALL be latched in that cycle and held for the frame.
REQ-016 Each bit value SHALL be the majority vote of RX_IN sampled at edges Prescale/2-1, Prescale/2, Prescale/2+1.
REQ-017 START: at edge Prescale-1, a sampled value of 1 (glitch) SHALL return to IDLE with no output pulse; otherwise next state DATA.
REQ-018 DATA: at edge Prescale-1 of each bit, the sampled bit SHALL be stored at bit position bit_cnt; after bit DATA_WIDTH-1, next state PARITY if latched PAR_EN=1, else STOP.
REQ-019 PARITY: at edge Prescale-1, an internal parity-error flag SHALL be set if sampled bit != (XOR of data bits) XOR PAR_TYP; next state STOP.
REQ-020 STOP: at edge Prescale-1, next state SHALL be IDLE unconditionally; a back-to-back start bit is detected by IDLE in the following cycle per REQ-015.
REQ-021 In the cycle after the last STOP edge: Stp_Err=1 if stop sample was 0; Par_Err=1 if the parity-error flag is set; Data_Valid=1 only if both are 0. All three are registered, high for exactly one cycle.
REQ-022 P_DATA SHALL update only when Data_Valid pulses and SHALL hold its value otherwise, including after errored or glitched frames.
REQ-023 Latency: Data_Valid SHALL assert exactly (DATA_WIDTH+2+PAR_EN) x Prescale cycles after the IDLE cycle that saw RX_IN=0.
REQ-024 Changes to PAR_EN, PAR_TYP or Prescale mid-frame SHALL NOT affect the current frame.

Reset
REQ-025 With rst=0, the state SHALL be IDLE, counters 0, P_DATA=0, Data_Valid=0, Par_Err=0, Stp_Err=0, parity-error flag cleared, immediately and independently of clk.
REQ-026 Reset mid-frame SHALL abandon the frame with no output pulse; after release, reception restarts only on a new RX_IN=0 in IDLE.

Verification
REQ-027 Prescale=8, PAR_EN=1, PAR_TYP=0, frame 0xA5 with parity 0 and stop 1 -> P_DATA=0xA5, Data_Valid pulse 88 cycles after start detect, no errors.
REQ-028 Same frame with parity bit 1 -> Par_Err one-cycle pulse, Data_Valid=0, P_DATA unchanged.
REQ-029 Prescale=16, PAR_EN=0, 0x5A with stop bit 0 -> Stp_Err pulse at 160 cycles, Data_Valid=0.
REQ-030 Prescale=16, RX_IN low for 3 cycles then high -> return to IDLE, no pulses; the next valid frame 0x0F -> Data_Valid, P_DATA=0x0F.
REQ-031 Prescale=32, PAR_EN=0, back-to-back frames 0x3C, 0xC3 with no idle gap -> two Data_Valid pulses 320 cycles apart, P_DATA 0x3C then 0xC3.
REQ-032 rst=0 during DATA bit 4 of frame 0xFF -> all outputs 0 immediately, no pulse after release; the next frame 0x81 is received correctly.

Source files
------------

// File: rtl/controller_rx.sv
// UART-style receiver: oversampled start/data/parity/stop framing with majority-vote
// bit sampling and registered one-cycle valid/error pulses.
module controller_rx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RX_IN,
    input  logic [5:0]            Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  Data_Valid,
    output logic                  Par_Err,
    output logic                  Stp_Err,
    output logic [2:0]            fsm_state
);

    localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                state, next_state;
    logic [5:0]            edge_cnt;
    logic [5:0]            prescale_q;
    logic [5:0]            half;
    logic [BCW-1:0]        bit_cnt;
    logic                  par_en_q, par_typ_q, par_flag;
    logic                  samp_a, samp_b, bit_val;
    logic [DATA_WIDTH-1:0] shift_data;
    logic                  bit_end;

    assign half      = {1'b0, prescale_q[5:1]};
    assign bit_end   = (edge_cnt == prescale_q - 6'd1);
    assign fsm_state = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (!RX_IN) next_state = START;
            START:   if (bit_end) next_state = bit_val ? IDLE : DATA;
            DATA:    if (bit_end && (bit_cnt == LAST_BIT)) next_state = par_en_q ? PARITY : STOP;
            PARITY:  if (bit_end) next_state = STOP;
            STOP:    if (bit_end) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // The IDLE cycle that sees the line low is edge 0 of the start bit, so counting resumes at 1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            edge_cnt   <= '0;
            bit_cnt    <= '0;
            prescale_q <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            par_flag   <= 1'b0;
            samp_a     <= 1'b0;
            samp_b     <= 1'b0;
            bit_val    <= 1'b0;
            shift_data <= '0;
            P_DATA     <= '0;
            Data_Valid <= 1'b0;
            Par_Err    <= 1'b0;
            Stp_Err    <= 1'b0;
        end else begin
            Data_Valid <= 1'b0;
            Par_Err    <= 1'b0;
            Stp_Err    <= 1'b0;
            if (state == IDLE) begin
                edge_cnt <= '0;
                bit_cnt  <= '0;
                if (!RX_IN) begin
                    edge_cnt   <= 6'd1;
                    prescale_q <= Prescale;
                    par_en_q   <= PAR_EN;
                    par_typ_q  <= PAR_TYP;
                    par_flag   <= 1'b0;
                end
            end else begin
                edge_cnt <= bit_end ? 6'd0 : edge_cnt + 6'd1;
                if (edge_cnt == half - 6'd1) samp_a <= RX_IN;
                if (edge_cnt == half) samp_b <= RX_IN;
                if (edge_cnt == half + 6'd1) begin
                    bit_val <= (samp_a & samp_b) | (samp_a & RX_IN) | (samp_b & RX_IN);
                end
                if (bit_end) begin
                    case (state)
                        DATA: begin
                            shift_data[bit_cnt] <= bit_val;
                            bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + BCW'(1);
                        end
                        PARITY: begin
                            if (bit_val != ((^shift_data) ^ par_typ_q)) par_flag <= 1'b1;
                        end
                        STOP: begin
                            Stp_Err    <= ~bit_val;
                            Par_Err    <= par_flag;
                            Data_Valid <= bit_val & ~par_flag;
                            if (bit_val && !par_flag) P_DATA <= shift_data;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_controller_rx.sv
// Bench for controller_rx: directed frame table, glitch and reset sequences, then
// randomized noisy frames checked against a frame-level model of the receiver.
module tb_controller_rx;
    localparam int DW = 8;

    logic          clk, rst, rx_in;
    logic [5:0]    prescale;
    logic          par_en, par_typ;
    logic [DW-1:0] p_data;
    logic          data_valid, par_err, stp_err;
    logic [2:0]    fsm_state;

    controller_rx #(.DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .RX_IN(rx_in), .Prescale(prescale),
        .PAR_EN(par_en), .PAR_TYP(par_typ), .P_DATA(p_data),
        .Data_Valid(data_valid), .Par_Err(par_err), .Stp_Err(stp_err),
        .fsm_state(fsm_state)
    );

    // clock / cycle index
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard
    typedef struct {
        int unsigned   cyc;
        logic          dv, pe, se;
        logic [DW-1:0] pd;
    } ev_t;

    typedef struct {
        logic [DW-1:0] data;
        logic [5:0]    pre;
        bit            pe, pt, pb, sb;
        int            gap;
        bit            xdv, xpe, xse;
        logic [DW-1:0] xpd;
    } vec_t;

    ev_t           exp_q[$];
    ev_t           mon_e;
    logic [DW-1:0] cur_pd = '0;
    logic [DW-1:0] model_pd = '0;
    int            n_checks = 0;
    int            n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor: every pulse must match the next expected frame outcome; P_DATA holds otherwise
    always @(negedge clk) begin
        if (!rst) begin
            cur_pd = '0;
        end else if (data_valid || par_err || stp_err) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {29'd0, data_valid, par_err, stp_err}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("pulse_cycle", cyc, mon_e.cyc);
                check("data_valid", {31'd0, data_valid}, {31'd0, mon_e.dv});
                check("par_err", {31'd0, par_err}, {31'd0, mon_e.pe});
                check("stp_err", {31'd0, stp_err}, {31'd0, mon_e.se});
                check("p_data", {24'd0, p_data}, {24'd0, mon_e.pd});
                cur_pd = mon_e.pd;
            end
        end else begin
            if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                mon_e = exp_q.pop_front();
                check("missed_pulse", {29'd0, data_valid, par_err, stp_err},
                      {29'd0, mon_e.dv, mon_e.pe, mon_e.se});
            end
            check("p_data_hold", {24'd0, p_data}, {24'd0, cur_pd});
        end
    end

    // driver tasks
    function automatic logic [5:0] pick_pre(input int unsigned k);
        case (k)
            0:       return 6'd8;
            1:       return 6'd16;
            default: return 6'd32;
        endcase
    endfunction

    task automatic line_cycles(input int n, input logic v);
        rx_in = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called at #1 after a posedge; the current cycle is the one IDLE sees the start bit in.
    task automatic send_frame(input logic [DW-1:0] d, input logic [5:0] p, input bit pe, input bit pt,
                              input bit pb, input bit sb, input bit noisy,
                              input bit xdv, input bit xpe, input bit xse, input logic [DW-1:0] xpd);
        logic bits[$];
        ev_t  e;
        int   pp;
        int   fc;
        pp = int'(p);
        prescale = p;
        par_en = pe;
        par_typ = pt;
        bits = {};
        bits.push_back(1'b0);
        for (int i = 0; i < DW; i++) bits.push_back(d[i]);
        if (pe) bits.push_back(pb);
        bits.push_back(sb);
        e.cyc = cyc + unsigned'(bits.size() * pp);
        e.dv = xdv;
        e.pe = xpe;
        e.se = xse;
        e.pd = xpd;
        exp_q.push_back(e);
        for (int b = 0; b < bits.size(); b++) begin
            fc = -1;
            if (noisy && $urandom_range(0, 1) == 1) fc = pp / 2 - 1 + int'($urandom_range(0, 2));
            for (int c = 0; c < pp; c++) begin
                rx_in = (c == fc) ? ~bits[b] : bits[b];
                if (b == 0 && c == 1) begin
                    prescale = pick_pre($urandom_range(0, 2));
                    par_en = 1'($urandom_range(0, 1));
                    par_typ = 1'($urandom_range(0, 1));
                end
                @(posedge clk);
                #1;
            end
        end
        rx_in = 1'b1;
    endtask

    vec_t tbl[8];

    initial begin
        logic [DW-1:0] d;
        logic [5:0]    p;
        bit            pe, pt, pb, sb, perr;

        tbl[0] = '{8'hA5, 6'd8,  1'b1, 1'b0, 1'b0, 1'b1, 4, 1'b1, 1'b0, 1'b0, 8'hA5};
        tbl[1] = '{8'hA5, 6'd8,  1'b1, 1'b0, 1'b1, 1'b1, 4, 1'b0, 1'b1, 1'b0, 8'hA5};
        tbl[2] = '{8'h5A, 6'd16, 1'b0, 1'b0, 1'b0, 1'b0, 4, 1'b0, 1'b0, 1'b1, 8'hA5};
        tbl[3] = '{8'h3C, 6'd32, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0, 8'h3C};
        tbl[4] = '{8'hC3, 6'd32, 1'b0, 1'b0, 1'b0, 1'b1, 3, 1'b1, 1'b0, 1'b0, 8'hC3};
        tbl[5] = '{8'h01, 6'd16, 1'b1, 1'b1, 1'b0, 1'b1, 2, 1'b1, 1'b0, 1'b0, 8'h01};
        tbl[6] = '{8'h00, 6'd8,  1'b1, 1'b0, 1'b1, 1'b0, 2, 1'b0, 1'b1, 1'b1, 8'h01};
        tbl[7] = '{8'hFE, 6'd8,  1'b1, 1'b1, 1'b0, 1'b1, 2, 1'b1, 1'b0, 1'b0, 8'hFE};

        // reset block
        rst = 1'b1;
        rx_in = 1'b1;
        prescale = 6'd8;
        par_en = 1'b0;
        par_typ = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("reset_p_data", {24'd0, p_data}, 32'd0);
        check("reset_data_valid", {31'd0, data_valid}, 32'd0);
        check("reset_par_err", {31'd0, par_err}, 32'd0);
        check("reset_stp_err", {31'd0, stp_err}, 32'd0);
        check("reset_state", {29'd0, fsm_state}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        line_cycles(5, 1'b1);

        // directed table
        for (int i = 0; i < 8; i++) begin
            send_frame(tbl[i].data, tbl[i].pre, tbl[i].pe, tbl[i].pt, tbl[i].pb, tbl[i].sb, 1'b0,
                       tbl[i].xdv, tbl[i].xpe, tbl[i].xse, tbl[i].xpd);
            if (tbl[i].xdv) model_pd = tbl[i].data;
            line_cycles(tbl[i].gap, 1'b1);
        end

        // short low pulse must be rejected as a glitch, then a good frame follows
        prescale = 6'd16;
        par_en = 1'b0;
        line_cycles(3, 1'b0);
        line_cycles(40, 1'b1);
        check("glitch_back_to_idle", {29'd0, fsm_state}, 32'd0);
        send_frame(8'h0F, 6'd16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h0F);
        model_pd = 8'h0F;
        line_cycles(4, 1'b1);

        // reset during data bit 4 of 0xFF
        prescale = 6'd16;
        par_en = 1'b0;
        par_typ = 1'b0;
        line_cycles(16, 1'b0);
        line_cycles(4 * 16 + 8, 1'b1);
        rst = 1'b0;
        #1;
        check("midframe_rst_p_data", {24'd0, p_data}, 32'd0);
        check("midframe_rst_data_valid", {31'd0, data_valid}, 32'd0);
        check("midframe_rst_par_err", {31'd0, par_err}, 32'd0);
        check("midframe_rst_stp_err", {31'd0, stp_err}, 32'd0);
        check("midframe_rst_state", {29'd0, fsm_state}, 32'd0);
        model_pd = '0;
        line_cycles(2, 1'b1);
        rst = 1'b1;
        line_cycles(200, 1'b1);
        send_frame(8'h81, 6'd16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h81);
        model_pd = 8'h81;
        line_cycles(3, 1'b1);

        // randomized noisy frames against the frame-level model
        for (int n = 0; n < 30; n++) begin
            d = 8'($urandom);
            p = pick_pre($urandom_range(0, 2));
            pe = 1'($urandom_range(0, 1));
            pt = 1'($urandom_range(0, 1));
            pb = ((^d) ^ pt) ^ ($urandom_range(0, 3) == 0);
            sb = ($urandom_range(0, 4) != 0);
            perr = pe && (pb != ((^d) ^ pt));
            send_frame(d, p, pe, pt, pb, sb, 1'b1, !perr && sb, perr, !sb,
                       (!perr && sb) ? d : model_pd);
            if (!perr && sb) model_pd = d;
            line_cycles(int'($urandom_range(0, 3)), 1'b1);
        end

        // final report
        for (int i = 0; i < 2000 && exp_q.size() > 0; i++) @(posedge clk);
        #1;
        check("pending_outcomes", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
